// File: rtl/piradip_axis_half_packer.sv
// Packs alternating half-strobed AXI4-Stream beats into fully-strobed beats.
// Fully-strobed beats pass through a single output register stage.
module piradip_axis_half_packer #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  input  logic                    flush,
  output logic                    pending,
  output logic [CNT_WIDTH-1:0]    flush_count
);

  localparam int unsigned HALF = DATA_WIDTH / 2;
  localparam int unsigned SW   = DATA_WIDTH / 8;
  localparam int unsigned HSW  = SW / 2;

  typedef enum logic {
    ST_EMPTY,
    ST_HALF
  } state_e;

  state_e                  state_q, state_d;
  logic [HALF-1:0]         hold_q, hold_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [SW-1:0]           strb_q, strb_d;
  logic                    valid_q, valid_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic                    lo_v, hi_v;
  logic                    is_full, is_half;
  logic [HALF-1:0]         payload;
  logic                    slot_free;
  logic                    full_in;
  logic                    accept;

  assign lo_v    = &s_axis_tstrb[HSW-1:0];
  assign hi_v    = &s_axis_tstrb[SW-1:HSW];
  assign is_full = lo_v & hi_v;
  assign is_half = lo_v ^ hi_v;
  assign payload = lo_v ? s_axis_tdata[HALF-1:0] : s_axis_tdata[DATA_WIDTH-1:HALF];

  assign slot_free = !valid_q | m_axis_tready;
  assign full_in   = s_axis_tvalid & is_full;

  // A full beat arriving behind a held half is stalled one cycle so the half
  // can be emitted on its own first.
  assign s_axis_tready = slot_free & !((state_q == ST_HALF) & full_in);
  assign accept        = s_axis_tvalid & s_axis_tready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    data_d  = data_q;
    strb_d  = strb_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    if (slot_free) begin
      valid_d = 1'b0;
      unique case (state_q)
        ST_EMPTY: begin
          if (accept && is_full) begin
            data_d  = s_axis_tdata;
            strb_d  = '1;
            valid_d = 1'b1;
          end else if (accept && is_half) begin
            hold_d  = payload;
            state_d = ST_HALF;
          end
        end
        ST_HALF: begin
          if (accept && is_half) begin
            data_d  = {payload, hold_q};
            strb_d  = '1;
            valid_d = 1'b1;
            state_d = ST_EMPTY;
          end else if (full_in || flush) begin
            data_d  = {{HALF{1'b0}}, hold_q};
            strb_d  = {{HSW{1'b0}}, {HSW{1'b1}}};
            valid_d = 1'b1;
            state_d = ST_EMPTY;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_EMPTY;
      hold_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_axis_tdata  = data_q;
  assign m_axis_tstrb  = strb_q;
  assign m_axis_tvalid = valid_q;
  assign pending       = (state_q == ST_HALF);
  assign flush_count   = cnt_q;

endmodule

// File: tb/tb_piradip_axis_half_packer.sv
// Directed and randomized checks of piradip_axis_half_packer against a
// transaction-level reference model of the packing rules.
module tb_piradip_axis_half_packer;

  localparam int unsigned DW   = 64;
  localparam int unsigned HW   = DW / 2;
  localparam int unsigned SW   = DW / 8;
  localparam int unsigned HSW  = SW / 2;
  localparam int unsigned CW   = 3;
  localparam int          CMAX = (1 << CW) - 1;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] s_axis_tdata;
  logic [SW-1:0] s_axis_tstrb;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [SW-1:0] m_axis_tstrb;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          flush;
  logic          pending;
  logic [CW-1:0] flush_count;

  piradip_axis_half_packer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .flush         (flush),
    .pending       (pending),
    .flush_count   (flush_count)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an output slot (at most one beat) and a queue of held halves.
  logic [DW-1:0] mo_data;
  logic [SW-1:0] mo_strb;
  bit            mo_valid;
  logic [HW-1:0] held[$];
  int            cnt_m;

  function automatic void model_reset();
    mo_data  = '0;
    mo_strb  = '0;
    mo_valid = 0;
    held.delete();
    cnt_m    = 0;
  endfunction

  localparam logic [SW-1:0] STRB_ALL  = '1;
  localparam logic [SW-1:0] STRB_LO   = {{HSW{1'b0}}, {HSW{1'b1}}};
  localparam logic [SW-1:0] STRB_HI   = {{HSW{1'b1}}, {HSW{1'b0}}};

  // Present inputs for one cycle; compare at the falling edge, then advance the model.
  task automatic cycle(input bit tv, input logic [DW-1:0] td, input logic [SW-1:0] ts,
                       input bit fl, input bit mr);
    logic [HSW-1:0] lo_s, hi_s;
    bit             lo, hi, full, half, free, exp_rdy, acc;
    logic [HW-1:0]  pay, first;
    s_axis_tvalid = tv;
    s_axis_tdata  = td;
    s_axis_tstrb  = ts;
    flush         = fl;
    m_axis_tready = mr;
    @(negedge aclk);
    lo_s = ts[HSW-1:0];
    hi_s = ts[SW-1:HSW];
    lo   = (lo_s == {HSW{1'b1}});
    hi   = (hi_s == {HSW{1'b1}});
    full = lo && hi;
    half = lo != hi;
    pay  = lo ? td[HW-1:0] : td[DW-1:HW];
    free = !mo_valid || mr;
    exp_rdy = free && !(held.size() == 1 && tv && full);
    check_val("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
    check_val("m_tvalid", 64'(m_axis_tvalid), 64'(mo_valid));
    check_val("m_tdata", 64'(m_axis_tdata), 64'(mo_data));
    check_val("m_tstrb", 64'(m_axis_tstrb), 64'(mo_strb));
    check_val("pending", 64'(pending), 64'(held.size()));
    check_val("flush_count", 64'(flush_count), 64'(cnt_m));
    acc = tv && exp_rdy;
    if (free) mo_valid = 0;
    if (acc && full) begin
      mo_data = td; mo_strb = STRB_ALL; mo_valid = 1;
    end else if (acc && half && held.size() == 0) begin
      held.push_back(pay);
    end else if (acc && half) begin
      first = held.pop_front();
      mo_data = {pay, first}; mo_strb = STRB_ALL; mo_valid = 1;
    end else if (held.size() == 1 && free && ((tv && full) || fl)) begin
      first = held.pop_front();
      mo_data = {{HW{1'b0}}, first}; mo_strb = STRB_LO; mo_valid = 1;
      if (cnt_m < CMAX) cnt_m++;
    end
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] lo_beat(input logic [HW-1:0] v);
    return {$urandom(), v};
  endfunction

  function automatic logic [DW-1:0] hi_beat(input logic [HW-1:0] v);
    return {v, $urandom()};
  endfunction

  task automatic idle(input int n, input bit mr);
    for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, mr);
  endtask

  initial begin
    logic [SW-1:0] ts;
    int            sel;
    aresetn = 1'b0;
    s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tstrb = '0; flush = 0; m_axis_tready = 0;
    model_reset();
    #12;
    check_val("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_val("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check_val("rst_pending", 64'(pending), 64'd0);
    check_val("rst_count", 64'(flush_count), 64'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // Full beats pass through.
    cycle(1, {(DW/4){4'hA}}, STRB_ALL, 0, 1);
    cycle(1, {(DW/4){4'hB}}, STRB_ALL, 0, 1);
    cycle(1, {(DW/4){4'hC}}, STRB_ALL, 0, 1);
    idle(2, 1);

    // Low then high half pair into one beat.
    cycle(1, lo_beat(32'h1111), STRB_LO, 0, 1);
    cycle(1, hi_beat(32'h2222), STRB_HI, 0, 1);
    idle(2, 1);

    // Held half followed by a full beat forces a partial.
    cycle(1, lo_beat(32'h1111), STRB_LO, 0, 1);
    cycle(1, {(DW/4){4'hF}}, STRB_ALL, 0, 1);
    cycle(1, {(DW/4){4'hF}}, STRB_ALL, 0, 1);
    idle(2, 1);
    check_val("count_after_mixed", 64'(flush_count), 64'd1);

    // Held half, idle, then flush.
    cycle(1, lo_beat(32'h3333), STRB_LO, 0, 1);
    idle(5, 1);
    cycle(0, '0, '0, 1, 1);
    idle(2, 1);
    check_val("count_after_flush", 64'(flush_count), 64'd2);

    // Output stall with half beats in flight.
    cycle(1, lo_beat(32'h4444), STRB_LO, 0, 1);
    cycle(1, hi_beat(32'h5555), STRB_HI, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, lo_beat(32'h6666), STRB_LO, 0, 0);
    cycle(1, lo_beat(32'h6666), STRB_LO, 0, 1);
    cycle(1, hi_beat(32'h7777), STRB_HI, 0, 1);
    idle(2, 1);

    // A null beat between halves is dropped.
    cycle(1, lo_beat(32'h8888), STRB_LO, 0, 1);
    cycle(1, rnd_data(), '0, 0, 1);
    cycle(1, hi_beat(32'h9999), STRB_HI, 0, 1);
    idle(2, 1);

    // Flush coinciding with a pairing half does nothing extra.
    cycle(1, lo_beat(32'hAAAA), STRB_LO, 0, 1);
    cycle(1, hi_beat(32'hBBBB), STRB_HI, 1, 1);
    idle(2, 1);
    check_val("count_no_pair_flush", 64'(flush_count), 64'd2);

    // Counter saturates.
    for (int i = 0; i < 8; i++) begin
      cycle(1, hi_beat(32'(i)), STRB_HI, 0, 1);
      cycle(0, '0, '0, 1, 1);
    end
    idle(2, 1);
    check_val("count_saturated", 64'(flush_count), 64'(CMAX));

    // Reset mid-operation drops the held half.
    cycle(1, lo_beat(32'hCCCC), STRB_LO, 0, 1);
    aresetn = 1'b0;
    model_reset();
    #2;
    check_val("midrst_pending", 64'(pending), 64'd0);
    check_val("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_val("midrst_count", 64'(flush_count), 64'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    idle(2, 1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3)      ts = STRB_LO;
      else if (sel < 6) ts = STRB_HI;
      else if (sel < 8) ts = STRB_ALL;
      else if (sel < 9) ts = '0;
      else              ts = SW'($urandom);
      cycle($urandom_range(0, 3) != 0, rnd_data(), ts,
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
    end
    idle(3, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
